dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_pkg.sv | 29 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_resp.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: bus constants, word/address types and the address-range helper
// shared by the data-memory responder and its storage array.
// Ports: none (package).

`ifndef DMEM_DEFINES
`define DMEM_DEFINES
`define ZERO_WORD     32'h0000_0000
`define BUS_REQ       1'b1
`define BUS_NREQ      1'b0
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`define MEM_BUS       31:0
`define MEM_ADDR_BUS  31:0
`endif

package dmem_resp_pkg;

    typedef logic [`MEM_BUS]      word_t;
    typedef logic [`MEM_ADDR_BUS] addr_t;

    localparam word_t ZERO_WORD = `ZERO_WORD;

    // A byte address is out of range once it reaches DEPTH_WORDS*4. The
    // comparison is done at 33 bits so the limit itself cannot overflow.
    function automatic logic addr_out_of_range(input addr_t addr, input int depth_words);
        return {1'b0, addr} >= (33'(depth_words) << 2);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH_WORDS x 32 storage, synchronous read and write.
// Ports:
//   clk    - clock
//   rd_en  - load rdata from mem[addr] at the edge
//   wr_en  - store wdata into mem[addr] at the edge
//   addr   - word index shared by read and write
//   wdata  - write word
//   rdata  - registered read word (holds until the next read)

module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH_WORDS];

    // NOTE: storage has no reset; contents survive reset and no reset
    // fan-out is spent on the array.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: fixed-latency data-memory responder. Captures one request in
// IDLE, waits LATENCY cycles, then acks for one cycle with read data / error.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   mem_req_i     - request (accepted only in IDLE)
//   mem_we_i      - write enable
//   mem_raddr_i   - byte read address
//   mem_waddr_i   - byte write address
//   mem_wdata_i   - write word
//   mem_rdata_o   - read word, valid with mem_ack_o, zero otherwise
//   mem_ack_o     - one-cycle completion pulse
//   mem_err_o     - out-of-range flag, valid with mem_ack_o
//   mem_busy_o    - transaction in flight (pipeline hold)

module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_raddr_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        mem_busy_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q;
    logic       cap_we;
    addr_t      cap_raddr, cap_waddr;
    word_t      cap_wdata;
    logic       ack_q, err_q, rd_zero_q;

    logic       cur_we;
    addr_t      cur_raddr, cur_waddr;
    logic       enter_resp, rd_oor, wr_oor;
    logic       rd_en, wr_en;
    logic [AW-1:0] arr_addr;
    word_t      arr_rdata;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mem_req_i == `BUS_REQ) state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == 3'd0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // In IDLE the transaction has not been captured yet; with LATENCY=0 the
    // RESP-entry read must therefore use the live request inputs.
    assign cur_we    = (state_q == S_IDLE) ? mem_we_i    : cap_we;
    assign cur_raddr = (state_q == S_IDLE) ? mem_raddr_i : cap_raddr;
    assign cur_waddr = (state_q == S_IDLE) ? mem_waddr_i : cap_waddr;

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign rd_oor     = addr_out_of_range(cur_raddr, DEPTH_WORDS);
    assign wr_oor     = addr_out_of_range(cur_waddr, DEPTH_WORDS);

    // Read on the RESP entry edge, write on the RESP exit edge: the single
    // port is never asked for both, and a same-address write returns old data.
    assign rd_en    = enter_resp && !rd_oor && !rst;
    assign wr_en    = (state_q == S_RESP) && (cap_we == `WRITE_ENABLE) && !wr_oor && !rst;
    assign arr_addr = wr_en ? cur_waddr[AW+1:2] : cur_raddr[AW+1:2];

    // NOTE: state uses non-blocking assignments and a synchronous reset
    // sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cap_we    <= `WRITE_DISABLE;
            cap_raddr <= '0;
            cap_waddr <= '0;
            cap_wdata <= ZERO_WORD;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && (mem_req_i == `BUS_REQ)) begin
                cap_we    <= mem_we_i;
                cap_raddr <= mem_raddr_i;
                cap_waddr <= mem_waddr_i;
                cap_wdata <= mem_wdata_i;
                cnt_q     <= CNT_LOAD;
            end else if ((state_q == S_WAIT) && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
            ack_q     <= enter_resp;
            err_q     <= enter_resp && (cur_we ? wr_oor : rd_oor);
            rd_zero_q <= enter_resp && rd_oor;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .addr  (arr_addr),
        .wdata (cap_wdata),
        .rdata (arr_rdata)
    );

    assign mem_ack_o   = ack_q;
    assign mem_err_o   = err_q;
    assign mem_rdata_o = (ack_q && !rd_zero_q) ? arr_rdata : ZERO_WORD;
    assign mem_busy_o  = (state_q != S_IDLE);

endmodule
